// File: rtl/npc_arch_state.sv
// Architectural state for the RV32 NPC core: GPR file (2R/1W, x0 hardwired), PC register,
// and the keyed write-back select mux. Define NPC_ARCH_STATE_WB_BYPASS_EN for same-cycle forwarding.
module npc_arch_state #(
  parameter int unsigned               ADDR_WIDTH = 5,
  parameter int unsigned               DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PC   = 32'h8000_0000,
  parameter int unsigned               NR_KEY     = 3,
  parameter int unsigned               KEY_LEN    = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ADDR_WIDTH-1:0]                 rs1addr,
  input  logic [ADDR_WIDTH-1:0]                 rs2addr,
  output logic [DATA_WIDTH-1:0]                 rs1data,
  output logic [DATA_WIDTH-1:0]                 rs2data,
  input  logic                                  wen,
  input  logic [ADDR_WIDTH-1:0]                 waddr,
  input  logic [KEY_LEN-1:0]                    wb_key,
  input  logic [NR_KEY*(KEY_LEN+DATA_WIDTH)-1:0] wb_lut,
  input  logic [DATA_WIDTH-1:0]                 wb_default,
  output logic [DATA_WIDTH-1:0]                 wdata,
  input  logic [DATA_WIDTH-1:0]                 pc_din,
  input  logic                                  pc_wen,
  output logic [DATA_WIDTH-1:0]                 pc
);

  localparam int unsigned P    = KEY_LEN + DATA_WIDTH;
  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic [KEY_LEN-1:0]    lut_key  [NR_KEY];
  logic [DATA_WIDTH-1:0] lut_data [NR_KEY];
  logic [NR_KEY-1:0]     lut_hit;
  logic [DATA_WIDTH-1:0] or_acc   [NR_KEY+1];

  logic [DATA_WIDTH-1:0] gpr_q [NREG];
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic                  gpr_we;

  // Matching entries are masked then OR-chained, so duplicate keys merge their data.
  assign or_acc[0] = '0;
  for (genvar g = 0; g < NR_KEY; g++) begin : g_lut
    assign lut_key[g]    = wb_lut[g*P+DATA_WIDTH +: KEY_LEN];
    assign lut_data[g]   = wb_lut[g*P +: DATA_WIDTH];
    assign lut_hit[g]    = (lut_key[g] == wb_key);
    assign or_acc[g+1]   = or_acc[g] | (lut_hit[g] ? lut_data[g] : '0);
  end

  assign wdata = (|lut_hit) ? or_acc[NR_KEY] : wb_default;

  always_comb begin
    pc_d   = pc_q;
    gpr_we = wen && (waddr != '0);
    if (pc_wen) begin
      pc_d = pc_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_q <= '{default: '0};
      pc_q  <= RESET_PC;
    end else begin
      if (gpr_we) begin
        gpr_q[waddr] <= wdata;
      end
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

  always_comb begin
    rs1data = '0;
    rs2data = '0;
    if (rs1addr != '0) begin
      rs1data = gpr_q[rs1addr];
    end
    if (rs2addr != '0) begin
      rs2data = gpr_q[rs2addr];
    end
`ifdef NPC_ARCH_STATE_WB_BYPASS_EN
    // Forward the in-flight write; rsNaddr != 0 is implied by the nonzero-waddr guard.
    if (gpr_we && (rs1addr == waddr)) begin
      rs1data = wdata;
    end
    if (gpr_we && (rs2addr == waddr)) begin
      rs2data = wdata;
    end
`endif
  end

endmodule

// File: tb/tb_npc_arch_state.sv
// Self-checking bench for npc_arch_state: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file, PC and LUT.
module tb_npc_arch_state;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NK = 3;
  localparam int KL = 7;
  localparam int P  = KL + DW;
  localparam logic [DW-1:0] RPC = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1addr, rs2addr, waddr;
  logic [DW-1:0]   rs1data, rs2data, wdata, pc, pc_din, wb_default;
  logic            wen, pc_wen;
  logic [KL-1:0]   wb_key;
  logic [NK*P-1:0] wb_lut;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] m_pc;

  npc_arch_state #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC), .NR_KEY(NK), .KEY_LEN(KL)
  ) dut (
    .clk(clk), .rst(rst), .rs1addr(rs1addr), .rs2addr(rs2addr),
    .rs1data(rs1data), .rs2data(rs2data), .wen(wen), .waddr(waddr),
    .wb_key(wb_key), .wb_lut(wb_lut), .wb_default(wb_default), .wdata(wdata),
    .pc_din(pc_din), .pc_wen(pc_wen), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_wdata();
    logic [P-1:0]  ent;
    logic [DW-1:0] acc;
    bit            any;
    acc = 0;
    any = 0;
    for (int i = 0; i < NK; i++) begin
      ent = wb_lut[i*P +: P];
      if (ent[P-1:DW] == wb_key) begin
        any = 1;
        acc = acc | ent[DW-1:0];
      end
    end
    return any ? acc : wb_default;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return 0;
`ifdef NPC_ARCH_STATE_WB_BYPASS_EN
    if (wen && waddr == a) return model_wdata();
`endif
    return m_rf[a];
  endfunction

  task automatic set_lut(input logic [KL-1:0] k0, input logic [DW-1:0] d0,
                         input logic [KL-1:0] k1, input logic [DW-1:0] d1,
                         input logic [KL-1:0] k2, input logic [DW-1:0] d2);
    wb_lut = {k2, d2, k1, d1, k0, d0};
  endtask

  // Apply one rising edge to both DUT and model, then settle just past the edge.
  task automatic do_edge();
    logic [DW-1:0] w;
    w = model_wdata();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      m_pc = RPC;
    end else begin
      if (wen && waddr != 0) m_rf[waddr] = w;
      if (pc_wen) m_pc = pc_din;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; pc_wen = 0; wen = 0;
    do_edge();
    checks++;
    if (pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RPC); end
    rst = 0; rs1addr = 5; pc_wen = 1; pc_din = pc + 4; #1;
    checks++;
    if (rs1data !== 32'h0) begin errors++; $display("FAIL reset_x5: got %h expected %h", rs1data, 32'h0); end
    do_edge();
    checks++;
    if (pc !== 32'h8000_0004) begin errors++; $display("FAIL reset_pc_next: got %h expected %h", pc, 32'h8000_0004); end
    pc_wen = 0;
  endtask

  task automatic test_x0();
    set_lut(7'h6F, 32'h1000, 7'h67, 32'h2000, 7'h03, 32'h3000);
    wb_key = 7'h7F; wb_default = 32'hDEAD_BEEF; wen = 1; waddr = 0; rs1addr = 0; #1;
    checks++;
    if (wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x0_wdata: got %h expected %h", wdata, 32'hDEAD_BEEF); end
    do_edge();
    wen = 0; #1;
    checks++;
    if (rs1data !== 32'h0) begin errors++; $display("FAIL x0_read: got %h expected %h", rs1data, 32'h0); end
  endtask

  task automatic test_lut();
    set_lut(7'h6F, 32'h1000, 7'h67, 32'h2000, 7'h03, 32'h3000);
    wb_default = 32'h5555; wb_key = 7'h6F; #1;
    checks++;
    if (wdata !== 32'h1000) begin errors++; $display("FAIL lut_hit: got %h expected %h", wdata, 32'h1000); end
    wb_key = 7'h13; #1;
    checks++;
    if (wdata !== 32'h5555) begin errors++; $display("FAIL lut_default: got %h expected %h", wdata, 32'h5555); end
    wb_key = 7'h03; #1;
    checks++;
    if (wdata !== 32'h3000) begin errors++; $display("FAIL lut_last: got %h expected %h", wdata, 32'h3000); end
  endtask

  task automatic test_dup_keys();
    set_lut(7'h03, 32'h00F0, 7'h6F, 32'h1000, 7'h03, 32'h0F00);
    wb_key = 7'h03; #1;
    checks++;
    if (wdata !== 32'h0FF0) begin errors++; $display("FAIL dup_keys: got %h expected %h", wdata, 32'h0FF0); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp_same;
    wb_key = 7'h7F; wen = 1;
    waddr = 10; wb_default = 32'h1234_5678; do_edge();
    waddr = 11; wb_default = 32'h0000_CAFE; do_edge();
    wen = 0; rs1addr = 10; rs2addr = 11; #1;
    checks++;
    if (rs1data !== 32'h1234_5678) begin errors++; $display("FAIL rd_x10: got %h expected %h", rs1data, 32'h1234_5678); end
    checks++;
    if (rs2data !== 32'h0000_CAFE) begin errors++; $display("FAIL rd_x11: got %h expected %h", rs2data, 32'h0000_CAFE); end
    rs2addr = 10; #1;
    checks++;
    if (rs2data !== rs1data || rs2data !== 32'h1234_5678) begin
      errors++; $display("FAIL same_addr: got %h/%h expected %h", rs1data, rs2data, 32'h1234_5678);
    end
`ifdef NPC_ARCH_STATE_WB_BYPASS_EN
    exp_same = 32'h1;
`else
    exp_same = 32'h1234_5678;
`endif
    wen = 1; waddr = 10; wb_default = 32'h1; rs2addr = 0; #1;
    checks++;
    if (rs1data !== exp_same) begin errors++; $display("FAIL same_cycle: got %h expected %h", rs1data, exp_same); end
    checks++;
    if (rs2data !== 32'h0) begin errors++; $display("FAIL port0_zero: got %h expected %h", rs2data, 32'h0); end
    do_edge();
    wen = 0; #1;
    checks++;
    if (rs1data !== 32'h1) begin errors++; $display("FAIL after_write: got %h expected %h", rs1data, 32'h1); end
  endtask

  task automatic test_hold_reset();
    logic [DW-1:0] held;
    held = pc;
    pc_wen = 0; pc_din = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      do_edge();
      checks++;
      if (pc !== held) begin errors++; $display("FAIL pc_hold%0d: got %h expected %h", i, pc, held); end
    end
    wen = 1; waddr = 3; wb_key = 7'h7F; wb_default = 32'h77; do_edge();
    rst = 1; wb_default = 32'h99; pc_wen = 1; do_edge();
    rst = 0; wen = 0; pc_wen = 0; rs1addr = 3; #1;
    checks++;
    if (rs1data !== 32'h0) begin errors++; $display("FAIL rst_x3: got %h expected %h", rs1data, 32'h0); end
    checks++;
    if (pc !== RPC) begin errors++; $display("FAIL rst_pc: got %h expected %h", pc, RPC); end
  endtask

  task automatic test_random();
    logic [KL-1:0] keys [4];
    logic [DW-1:0] e;
    keys[0] = 7'h03; keys[1] = 7'h13; keys[2] = 7'h6F; keys[3] = 7'h67;
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 31) == 0);
      wen     = $urandom_range(0, 1);
      waddr   = $urandom_range(0, 31);
      rs1addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
      rs2addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
      set_lut(keys[$urandom_range(0, 3)], $urandom, keys[$urandom_range(0, 3)], $urandom,
              keys[$urandom_range(0, 3)], $urandom);
      wb_key     = ($urandom_range(0, 4) == 0) ? 7'h7E : keys[$urandom_range(0, 3)];
      wb_default = $urandom;
      pc_wen     = $urandom_range(0, 1);
      pc_din     = $urandom;
      #1;
      e = model_wdata();
      checks++;
      if (wdata !== e) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, wdata, e); end
      e = model_read(rs1addr);
      checks++;
      if (rs1data !== e) begin errors++; $display("FAIL rnd_rs1[%0d] a=%0d: got %h expected %h", n, rs1addr, rs1data, e); end
      e = model_read(rs2addr);
      checks++;
      if (rs2data !== e) begin errors++; $display("FAIL rnd_rs2[%0d] a=%0d: got %h expected %h", n, rs2addr, rs2data, e); end
      checks++;
      if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, pc, m_pc); end
      do_edge();
    end
    rst = 0; wen = 0; pc_wen = 0;
  endtask

  initial begin
    rst = 1; wen = 0; pc_wen = 0; waddr = 0; rs1addr = 0; rs2addr = 0;
    wb_key = 0; wb_lut = '0; wb_default = 0; pc_din = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    m_pc = RPC;
    #2;
    test_reset();
    test_x0();
    test_lut();
    test_dup_keys();
    test_write_read();
    test_hold_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
